// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage. Owns the HI/LO
// architectural registers, tracks the in-flight operation, and raises the
// stall request for HI/LO-touching instructions waiting in D.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDUse_D,
    output logic        Busy,
    output logic        MD_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Two's-complement magnitude of a 32-bit value (0x80000000 maps to itself).
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    state_t         state_r, state_s;
    logic [CW-1:0]  count_r, count_s;
    logic [31:0]    pend_hi_r, pend_hi_s;
    logic [31:0]    pend_lo_r, pend_lo_s;
    logic           pend_wr_r, pend_wr_s;
    logic [31:0]    hi_r, hi_s;
    logic [31:0]    lo_r, lo_s;

    logic [63:0]    smul_s;
    logic [63:0]    umul_s;
    logic [31:0]    abs_a_s;
    logic [31:0]    abs_b_s;
    logic [31:0]    sdiv_b_s;
    logic [31:0]    udiv_b_s;
    logic [31:0]    sq_mag_s;
    logic [31:0]    sr_mag_s;
    logic [31:0]    res_hi_s;
    logic [31:0]    res_lo_s;
    logic           res_wr_s;

    // Full-width results for the operands presented this cycle; only the one
    // selected by MDOp is latched into the pending registers at launch.
    always_comb begin
        smul_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        umul_s   = {32'd0, A} * {32'd0, B};
        abs_a_s  = magnitude(A);
        abs_b_s  = magnitude(B);
        // A zero divisor is replaced by one so the divider never sees zero;
        // its result is discarded by clearing res_wr_s below.
        sdiv_b_s = (B == 32'd0) ? 32'd1 : abs_b_s;
        udiv_b_s = (B == 32'd0) ? 32'd1 : B;
        sq_mag_s = abs_a_s / sdiv_b_s;
        sr_mag_s = abs_a_s % sdiv_b_s;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        res_wr_s = 1'b0;
        case (MDOp)
            OP_MULT: begin
                res_hi_s = smul_s[63:32];
                res_lo_s = smul_s[31:0];
                res_wr_s = 1'b1;
            end
            OP_MULTU: begin
                res_hi_s = umul_s[63:32];
                res_lo_s = umul_s[31:0];
                res_wr_s = 1'b1;
            end
            OP_DIV: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                res_lo_s = (A[31] ^ B[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
                res_hi_s = A[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
                res_wr_s = (B != 32'd0);
            end
            OP_DIVU: begin
                res_lo_s = A / udiv_b_s;
                res_hi_s = A % udiv_b_s;
                res_wr_s = (B != 32'd0);
            end
            default: begin
                res_wr_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: launch, countdown, commit and the mthi/mtlo writes.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        pend_wr_s = pend_wr_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        case (state_r)
            IDLE: begin
                if (Start && is_long_op(MDOp)) begin
                    state_s   = RUN;
                    count_s   = ((MDOp == OP_MULT) || (MDOp == OP_MULTU)) ?
                                CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    pend_hi_s = res_hi_s;
                    pend_lo_s = res_lo_s;
                    pend_wr_s = res_wr_s;
                end else if (Start && (MDOp == OP_MTHI)) begin
                    hi_s = A;
                end else if (Start && (MDOp == OP_MTLO)) begin
                    lo_s = A;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // Start is deliberately ignored here: nothing may disturb an
                // operation in flight.
                if (count_r == CW'(1)) begin
                    state_s = IDLE;
                    count_s = '0;
                    if (pend_wr_r) begin
                        hi_s = pend_hi_r;
                        lo_s = pend_lo_r;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    count_s = count_r - CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                count_s = '0;
            end
        endcase
    end

    // State and architectural register update; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= '0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            pend_wr_r <= pend_wr_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
        end
    end

    assign Busy     = (state_r == RUN);
    assign HI       = hi_r;
    assign LO       = lo_r;
    // Combinational so the D-stage op right behind a fresh launch is held
    // in the very cycle the launch is in E.
    assign MD_Stall = MDUse_D & (Busy | (Start & is_long_op(MDOp)));

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: launches push expected HI/LO and busy length,
// a monitor pops and compares whenever Busy falls.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDUse_D;
    logic        Busy;
    logic        MD_Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .MDUse_D (MDUse_D),
        .Busy    (Busy),
        .MD_Stall(MD_Stall),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural reference: plain 64-bit integer arithmetic.
    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] hi, inout logic [31:0] lo);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            3'd4: if (b != 32'd0) begin q = ua / ub; r = ua % ub; hi = r[31:0]; lo = q[31:0]; end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endfunction

    // Monitor: count Busy cycles, and on each falling edge of Busy compare
    // HI/LO and the busy length against the oldest expected entry.
    int   busy_cnt  = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (Busy === 1'b1) begin
            busy_cnt++;
        end else if (prev_busy) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_commit: got HI=%h LO=%h expected no activity", HI, LO);
            end else begin
                e = sb_q.pop_front();
                check32("commit_hi", HI, e.hi);
                check32("commit_lo", LO, e.lo);
                check32("busy_len", 32'(busy_cnt), 32'(e.cycles));
            end
            busy_cnt = 0;
        end
        prev_busy = (Busy === 1'b1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch a long op; optionally inject an ignored div at cycle offset inj
    // or assert reset at cycle offset rst_at.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input int inj, input int rst_at);
        int          n;
        logic [31:0] eh, el;
        n  = (op <= 3'd2) ? MULT_N : DIV_N;
        eh = m_hi;
        el = m_lo;
        ref_md(op, a, b, eh, el);
        tick;
        Start   = 1'b1;
        MDOp    = op;
        A       = a;
        B       = b;
        MDUse_D = use_d;
        sb_q.push_back('{hi: eh, lo: el, cycles: n});
        m_hi = eh;
        m_lo = el;
        #1;
        check1("stall_launch", MD_Stall, use_d);
        for (int k = 1; k <= n; k++) begin
            tick;
            Start = (k == inj);
            MDOp  = (k == inj) ? 3'd3 : 3'($urandom_range(0, 7));
            A     = $urandom;
            B     = $urandom;
            reset = (k == rst_at);
            if (k == rst_at) begin
                sb_q[0] = '{hi: 32'd0, lo: 32'd0, cycles: k};
                m_hi = 32'd0;
                m_lo = 32'd0;
            end
            #1;
            check1("stall_busy", MD_Stall, use_d);
            if (k == rst_at) begin
                tick;
                reset = 1'b0;
                Start = 1'b0;
                #1;
                check32("abort_hi", HI, 32'd0);
                check32("abort_lo", LO, 32'd0);
                check1("abort_busy", Busy, 1'b0);
                for (int j = 0; j < n; j++) begin
                    tick;
                end
                check32("no_commit_hi", HI, 32'd0);
                check32("no_commit_lo", LO, 32'd0);
                check1("no_commit_busy", Busy, 1'b0);
                return;
            end
        end
        tick;
        Start = 1'b0;
        MDOp  = 3'($urandom_range(0, 7));
        #1;
        check1("busy_done", Busy, 1'b0);
        check1("stall_done", MD_Stall, 1'b0);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        tick;
        Start   = 1'b1;
        MDOp    = op;
        A       = a;
        B       = $urandom;
        MDUse_D = 1'b1;
        ref_md(op, a, 32'd0, m_hi, m_lo);
        #1;
        check1("mt_stall", MD_Stall, 1'b0);
        tick;
        Start = 1'b0;
        #1;
        check32("mt_hi", HI, m_hi);
        check32("mt_lo", LO, m_lo);
        check1("mt_busy", Busy, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset   = 1'b1;
        Start   = 1'b0;
        MDOp    = 3'd0;
        A       = 32'd0;
        B       = 32'd0;
        MDUse_D = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            MDOp    = 3'($urandom_range(0, 7));
            MDUse_D = 1'b1;
            #1;
            check32("idle_hi", HI, 32'd0);
            check32("idle_lo", LO, 32'd0);
            check1("idle_busy", Busy, 1'b0);
            check1("idle_stall", MD_Stall, 1'b0);
        end

        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 0, 0);
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 0, 0);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 0, 0);
        mt(3'd5, 32'h11);
        mt(3'd6, 32'h22);
        run_op(3'd4, 32'd7, 32'd0, 1'b1, 0, 0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0);
        run_op(3'd3, 32'h0000000B, 32'd0, 1'b1, 0, 0);
        run_op(3'd1, $urandom, $urandom, 1'b1, 2, 0);
        mt(3'd5, 32'h1234);
        run_op(3'd3, 32'h12345678, 32'h00000013, 1'b1, 0, 3);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if (op >= 3'd5) begin
                mt(op, a);
            end else begin
                run_op(op, a, b, 1'($urandom_range(0, 1)), 0, 0);
            end
        end

        tick;
        tick;
        check32("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Holds the HI/LO architectural registers.
- It is the responder side of hazard stalling. The stall controller only reads instruction words. This block holds the busy state the controller cannot see, and drives the stall request for any HI/LO-touching instruction in D.
- Executes mult, multu, div, divu, mthi and mtlo. HI/LO values are read out to the E-stage forwarding/result mux.

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu (≥1).
- DIV_CYCLES, 10, Busy duration in cycles for div/divu (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  E-stage instruction is a valid MD op this cycle; qualifies MDOp
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  rs operand, forwarded
- B  input  32  rt operand, forwarded
- MDUse_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Busy  output  1  a multiply or divide is in flight
- MD_Stall  output  1  stall request to the pipeline, ORed into the global Stall
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset: a synchronous edge with reset=1 sets HI=0, LO=0, the internal counter to 0, Busy=0 and the pending result to 0. Reset wins over any simultaneous Start. Reset during an in-flight operation aborts it, and no HI/LO commit occurs.
- State machine, two states:
  - IDLE (count==0): Busy=0.
  - RUN (count≠0): Busy=1.
- IDLE → RUN: at the edge where Start=1, MDOp∈{1..4} and Busy=0.
  - count loads MULT_CYCLES for ops 1–2, DIV_CYCLES for ops 3–4.
  - The full 64-bit result is computed from A/B sampled at this edge and stored in pending {hi,lo}.
- RUN: count decrements by 1 per edge.
  - At the edge where count goes 1→0, pending hi/lo is written to HI/LO and the state returns to IDLE.
- Latency: Start at cycle T gives Busy=1 for cycles T+1..T+N. New HI/LO are visible in cycle T+N+1, the same cycle Busy=0.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}=product.
  - multu: unsigned 32×32→64.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Division by zero (B==0): the op still occupies DIV_CYCLES, but HI/LO are left unchanged at commit.
- mthi/mtlo: Start=1 with MDOp=5/6 and Busy=0 writes HI=A or LO=A at that edge. Busy is not asserted.
- Start while Busy=1, for any MDOp: ignored with no state change. The pipeline guarantees this does not occur via MD_Stall; the guard is still mandatory.
- MD_Stall = MDUse_D & (Busy | (Start & MDOp∈{1..4})). This is combinational with no registered delay.
  - The term covering cycle T covers an MD op in D directly behind a just-issued mult/div.
  - MD_Stall never depends on MDUse_D when Busy=0 and Start=0.
- HI/LO change only on: mthi, mtlo, a RUN→IDLE commit, or reset.
- A commit edge and a new Start edge cannot coincide, since Start is ignored while Busy=1 and count 1→0 happens while Busy=1. The earliest new launch is cycle T+N+1.

Test Plan:
- Reset then idle → HI=0, LO=0, Busy=0 and MD_Stall=0 for 20 cycles with MDUse_D=1.
- mult A=0xFFFFFFFE, B=3 at T → Busy=1 for T+1..T+5; at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=0x11, LO=0x22 → both unchanged, Busy was high 10 cycles.
- Stall handshake: Start=1/MDOp=1 with MDUse_D=1 → MD_Stall=1 in cycles T..T+5 and 0 at T+6. Same with MDUse_D=0 → MD_Stall stays 0.
- Start=1, MDOp=3 at T+2 during a mult launched at T → ignored: mult result committed at T+6, Busy low at T+6. mthi A=0x1234 when idle → HI=0x1234 the next cycle, Busy stays 0.
- reset=1 at T+3 of a div → HI/LO=0 and Busy=0 at T+4, and no commit occurs at T+11.
